// File: rtl/sap1_datapath.sv
// SAP-1 register/bus datapath: decodes the 12-bit control word into W-bus drivers
// and register loads for PC, MAR, RAM, IR, A, B, ALU and the output register.
module sap1_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] con_word,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [3:0]  opcode,
  output logic [7:0]  out_port,
  output logic [3:0]  pc,
  output logic [7:0]  bus,
  output logic        carry,
  output logic        bus_conflict
);

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_n;
    logic ce_n;
    logic li_n;
    logic ei_n;
    logic la_n;
    logic ea;
    logic su;
    logic eu;
    logic lb_n;
    logic lo_n;
  } ctrl_t;

  ctrl_t      ctl;
  logic [3:0] mar;
  logic [7:0] ir;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] out_reg;
  logic [7:0] ram [16];
  logic [7:0] alu_result;
  logic       alu_carry;
  logic [4:0] drivers;

  assign ctl = ctrl_t'(con_word);

  // Subtraction is A + ~B + 1, so the carry out doubles as "no borrow" (A >= B).
  always_comb begin
    if (ctl.su) begin
      {alu_carry, alu_result} = {1'b0, a_reg} + {1'b0, ~b_reg} + 9'd1;
    end else begin
      {alu_carry, alu_result} = {1'b0, a_reg} + {1'b0, b_reg};
    end
  end

  // More than one bit set means at least two drivers fight for the bus.
  assign drivers      = {ctl.ep, ~ctl.ce_n, ~ctl.ei_n, ctl.ea, ctl.eu};
  assign bus_conflict = (drivers & (drivers - 5'd1)) != 5'd0;

  // NOTE: bus gets a default before the priority chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus = 8'h00;
    if (ctl.ep)          bus = {4'h0, pc};
    else if (!ctl.ce_n)  bus = ram[mar];
    else if (!ctl.ei_n)  bus = {4'h0, ir[3:0]};
    else if (ctl.ea)     bus = a_reg;
    else if (ctl.eu)     bus = alu_result;
  end

  // NOTE: non-blocking assignments make every load sample the pre-edge bus,
  // so A <= ALU(old A, old B) and Ea with La_n=0 simply reload the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= 4'h0;
      mar     <= 4'h0;
      ir      <= 8'h00;
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      out_reg <= 8'h00;
      carry   <= 1'b0;
    end else begin
      if (ctl.cp)                pc      <= pc + 4'd1;
      if (!ctl.lm_n)             mar     <= bus[3:0];
      if (!ctl.li_n)             ir      <= bus;
      if (!ctl.la_n)             a_reg   <= bus;
      if (!ctl.lb_n)             b_reg   <= bus;
      if (!ctl.lo_n)             out_reg <= bus;
      if (!ctl.la_n && ctl.eu)   carry   <= alu_carry;
    end
  end

  // NOTE: the RAM array has no reset; the program survives rst and is only
  // writable through the load port while rst is held.
  always_ff @(posedge clk) begin
    if (rst && prog_we) ram[prog_addr] <= prog_data;
  end

  assign opcode   = ir[7:4];
  assign out_port = out_reg;

endmodule

// File: tb/tb_sap1_datapath.sv
// Self-checking bench for sap1_datapath: directed program/edge scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_sap1_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] con_word;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  out_port;
  logic [3:0]  pc;
  logic [7:0]  bus;
  logic        carry;
  logic        bus_conflict;

  sap1_datapath dut (
    .clk(clk), .rst(rst), .con_word(con_word), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .opcode(opcode),
    .out_port(out_port), .pc(pc), .bus(bus), .carry(carry),
    .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int unsigned m_pc, m_mar, m_ir, m_a, m_b, m_out, m_carry;
  int unsigned m_ram [16];
  bit          model_valid = 0;

  localparam logic [11:0] NOP = 12'h3E3;
  localparam logic [11:0] SHOW_A = 12'h3F3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int unsigned alu_sum(input bit su);
    // Subtract as A plus the two's complement of B; a sum >= 256 means carry.
    return su ? (m_a + (256 - m_b)) : (m_a + m_b);
  endfunction

  function automatic int unsigned model_bus(input logic [11:0] cw);
    if (cw[10])      return m_pc;
    else if (!cw[8]) return m_ram[m_mar];
    else if (!cw[6]) return m_ir % 16;
    else if (cw[4])  return m_a;
    else if (cw[2])  return alu_sum(cw[3]) % 256;
    return 0;
  endfunction

  function automatic bit model_conflict(input logic [11:0] cw);
    int n = 0;
    if (cw[10]) n++;
    if (!cw[8]) n++;
    if (!cw[6]) n++;
    if (cw[4])  n++;
    if (cw[2])  n++;
    return n > 1;
  endfunction

  // One cycle: drive at the falling edge, compare mid-cycle, advance the model at
  // the rising edge, and return 1 time unit later so callers can sample outputs.
  task automatic step(input logic [11:0] cw, input logic r = 1'b0,
                      input logic we = 1'b0, input logic [3:0] wa = 4'h0,
                      input logic [7:0] wd = 8'h00);
    int unsigned b;
    @(negedge clk);
    con_word  = cw;
    rst       = r;
    prog_we   = we;
    prog_addr = wa;
    prog_data = wd;
    #1;
    b = model_bus(cw);
    if (model_valid) begin
      check("bus", {24'h0, bus}, b);
      check("bus_conflict", {31'h0, bus_conflict}, {31'h0, model_conflict(cw)});
      check("pc", {28'h0, pc}, m_pc);
      check("opcode", {28'h0, opcode}, m_ir / 16);
      check("out_port", {24'h0, out_port}, m_out);
      check("carry", {31'h0, carry}, m_carry);
    end
    @(posedge clk);
    if (r) begin
      if (we) m_ram[wa] = wd;
      m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0; m_carry = 0;
      model_valid = 1;
    end else begin
      if (!cw[5] && cw[2]) m_carry = (alu_sum(cw[3]) >= 256) ? 1 : 0;
      if (cw[11]) m_pc = (m_pc + 1) % 16;
      if (!cw[9]) m_mar = b % 16;
      if (!cw[7]) m_ir = b;
      if (!cw[5]) m_a = b;
      if (!cw[1]) m_b = b;
      if (!cw[0]) m_out = b;
    end
    #1;
  endtask

  task automatic goto_pc(input int unsigned n);
    while (m_pc != n) step(12'hBE3);
  endtask

  task automatic load_reg(input int unsigned addr, input bit to_b);
    goto_pc(addr);
    step(12'h5E3);
    step(to_b ? 12'h2E1 : 12'h2C3);
  endtask

  task automatic fetch();
    step(12'h5E3);
    step(12'hBE3);
    step(12'h263);
  endtask

  task automatic run_instr(input logic [11:0] t4, input logic [11:0] t5, input logic [11:0] t6);
    fetch();
    step(t4);
    step(t5);
    step(t6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] image [16];
    image = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h33, 8'h5A, 8'hA5,
              8'h7E, 8'h10, 8'h14, 8'h18, 8'hF0, 8'h20, 8'h05, 8'h07};
    rst = 1'b1; con_word = NOP; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;

    // Reset with program load
    for (int i = 0; i < 16; i++) step(NOP, 1'b1, 1'b1, i[3:0], image[i]);
    step(NOP, 1'b1);
    step(NOP, 1'b1);
    check("reset_pc", {28'h0, pc}, 32'h0);
    check("reset_opcode", {28'h0, opcode}, 32'h0);
    check("reset_out", {24'h0, out_port}, 32'h0);
    check("reset_bus", {24'h0, bus}, 32'h0);
    check("reset_carry", {31'h0, carry}, 32'h0);
    check("reset_conflict", {31'h0, bus_conflict}, 32'h0);
    step(NOP);

    // Fetch, then the LDA/ADD/SUB/OUT program
    step(12'h5E3);
    step(12'hBE3);
    check("fetch_pc", {28'h0, pc}, 32'h1);
    step(12'h263);
    check("fetch_opcode", {28'h0, opcode}, 32'h0);
    step(12'h1A3);
    check("fetch_ir_operand", {24'h0, bus}, 32'h09);
    step(12'h2C3);
    step(NOP);
    run_instr(12'h1A3, 12'h2E1, 12'h3C7);
    run_instr(12'h1A3, 12'h2E1, 12'h3CF);
    run_instr(12'h3F2, NOP, NOP);
    check("prog_out", {24'h0, out_port}, 32'h0C);
    check("prog_carry", {31'h0, carry}, 32'h1);
    step(SHOW_A);
    check("prog_a", {24'h0, bus}, 32'h0C);

    // ALU edges
    load_reg(12, 0);
    load_reg(13, 1);
    step(12'h3C7);
    check("alu_add_carry", {31'h0, carry}, 32'h1);
    step(SHOW_A);
    check("alu_add_a", {24'h0, bus}, 32'h10);
    load_reg(14, 0);
    load_reg(15, 1);
    step(12'h3CF);
    check("alu_sub_carry", {31'h0, carry}, 32'h0);
    step(SHOW_A);
    check("alu_sub_a", {24'h0, bus}, 32'hFE);

    // Bus conflict
    step(NOP, 1'b1);
    goto_pc(3);
    step(12'h6E3);
    check("conflict_flag", {31'h0, bus_conflict}, 32'h1);
    check("conflict_bus", {24'h0, bus}, 32'h03);
    check("conflict_pc", {28'h0, pc}, 32'h3);

    // PC wrap
    goto_pc(15);
    step(12'hBE3);
    check("pc_wrap", {28'h0, pc}, 32'h0);

    // Reset during T5 of ADD
    step(NOP, 1'b1);
    run_instr(12'h1A3, 12'h2C3, NOP);
    fetch();
    step(12'h1A3);
    step(12'h2E1, 1'b1);
    check("midrst_pc", {28'h0, pc}, 32'h0);
    check("midrst_opcode", {28'h0, opcode}, 32'h0);
    check("midrst_out", {24'h0, out_port}, 32'h0);
    step(SHOW_A);
    check("midrst_a", {24'h0, bus}, 32'h0);
    goto_pc(9);
    step(12'h5E3);
    step(12'h2E3);
    check("ram9_kept", {24'h0, bus}, 32'h10);
    step(NOP, 1'b0, 1'b1, 4'h9, 8'hAA);
    step(12'h2E3);
    check("ram9_no_we", {24'h0, bus}, 32'h10);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      logic r;
      r = ($urandom_range(0, 24) == 0);
      step(12'($urandom), r, 1'($urandom), 4'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sap1_datapath.md
# sap1_datapath

Register/bus datapath of the SAP-1 computer, directly downstream of the control sequencer. Each cycle it decodes the 12-bit control word into bus-driver enables and register loads. It contains:
- the program counter, MAR, 16x8 RAM, instruction register, accumulator A, B register, add/sub ALU and output register;
- the opcode return path (IR[7:4]) that feeds the sequencer.

## Interface
- No parameters (widths fixed: 8-bit bus, 4-bit address, 16-word RAM).
- clk  in  1  system clock; all datapath state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- con_word  in  12  control word, bit 11..0 = Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n.
- prog_we  in  1  RAM program-load write strobe; honoured only while rst=1.
- prog_addr  in  4  RAM program-load address.
- prog_data  in  8  RAM program-load data.
- opcode  out  4  IR[7:4], to sequencer.
- out_port  out  8  output register contents.
- pc  out  4  program counter (observation).
- bus  out  8  current W-bus value (observation).
- carry  out  1  registered ALU carry flag.
- bus_conflict  out  1  combinational; more than one bus driver enabled this cycle.

## Operation
- Bus drivers (combinational), priority Ep > CE_n > Ei_n > Ea > Eu:
  - Ep=1: bus={4'h0,PC}.
  - CE_n=0: bus=RAM[MAR].
  - Ei_n=0: bus={4'h0,IR[3:0]}.
  - Ea=1: bus=A.
  - Eu=1: bus=ALU.
  - No driver: bus=8'h00.
  - Two or more drivers: bus_conflict=1; bus takes the highest-priority source.
- ALU (combinational): Su=0: {c,r}=A+B; Su=1: {c,r}=A+~B+1, so c=1 iff A>=B (no borrow). Result is 8 bits, mod 256.
- Loads on rising edge, all sampling the pre-edge bus:
  - Lm_n=0: MAR<=bus[3:0].
  - Li_n=0: IR<=bus.
  - La_n=0: A<=bus.
  - Lb_n=0: B<=bus.
  - Lo_n=0: OUT<=bus.
- Cp=1: PC<=PC+1, wrapping 15->0.
- carry<=ALU c only when La_n=0 and Eu=1 in the same cycle; otherwise it holds.
- RAM is read-only during execution (no store instruction). RAM read is asynchronous from MAR.
- Reset:
  - PC, MAR, IR, A, B, OUT, carry cleared to 0, so opcode=0, out_port=0, pc=0.
  - RAM contents are not cleared.
  - While rst=1 and prog_we=1: RAM[prog_addr]<=prog_data on the rising edge. prog_we is ignored when rst=0.
- NOP word 12'h3E3 drives nothing and loads nothing: bus=0x00, all state holds.

## Timing
- The sequencer changes con_word on the falling edge; the datapath samples on the rising edge, giving a half-cycle setup margin.
- Every load has 1-cycle latency: the value is visible on outputs after the same rising edge.
- Simultaneous Ep and Cp (legal): bus carries the old PC; PC increments at the edge.
- La_n=0 with Eu=1: A<=f(old A, old B) with no combinational loop, because the ALU reads register outputs.
- Load and drive of the same register in one cycle (e.g. Ea with La_n=0): the register reloads its own value.
- rst overrides con_word in the same cycle; rst asserted mid-instruction clears all registers at the next edge.
- bus_conflict is not registered and does not inhibit loads.

## Test plan
- Reset: rst=1 for 2 cycles, then con_word=3E3 -> pc=0, opcode=0, out_port=0x00, bus=0x00, carry=0, bus_conflict=0.
- Fetch: load RAM[0]=0x09, release rst, apply 5E3, BE3, 263 on successive cycles.
  - After cycle 1: MAR=0.
  - After cycle 2: pc=1.
  - After cycle 3: IR=0x09, opcode=0.
- Program run: load RAM[0..4]=09,1A,2B,E0,F0 and RAM[9]=0x10, RAM[A]=0x14, RAM[B]=0x18, then run with control_sequencer.
  - After the OUT instruction: out_port=0x0C, A=0x0C, carry=1.
- ALU edges:
  - A=0xF0, B=0x20, con_word 3C7 -> A=0x10, carry=1.
  - A=0x05, B=0x07, con_word 3CF -> A=0xFE, carry=0.
- Conflict: con_word 6E3 (Ep plus CE_n) with pc=3 -> bus_conflict=1, bus=0x03. No register changes.
- Wrap and reset:
  - pc=15 with con_word BE3 -> pc=0.
  - rst pulsed during T5 of ADD -> all registers 0 at next edge, RAM[9] still 0x10.
  - prog_we=1 with rst=0 -> RAM unchanged.
